intra_mb_scheduler: RTL and testbench
=====================================

Name: intra_mb_scheduler

Overview:
Frame-level sequencer for the intra encoder datapath. Walks a WIDTH x LENGTH frame in raster order of 16x16 macroblocks. Per macroblock it issues sixteen luma 4x4 jobs one at a time, then one chroma-blue 8x8 job and one chroma-red 8x8 job together. It sits between the frame control logic and the luma4x4 / chromab8x8 / chromar8x8 engines, and consumes their done pulses.

Parameters:
WIDTH, 1280, frame width in pixels; multiple of 16.
LENGTH, 720, frame height in pixels; multiple of 16.
MB_COLS, WIDTH/16, derived; macroblocks per row (80).
MB_ROWS, LENGTH/16, derived; macroblock rows (45).

Ports:
clk  in  1  clock; all logic on the rising edge.
reset  in  1  asynchronous, active-low reset.
enable  in  1  global run enable; when low, no new start pulses are issued.
frame_start  in  1  single-cycle request to encode one frame.
done_luma4x4  in  1  single-cycle pulse: current luma 4x4 job complete.
done_chromab8x8  in  1  single-cycle pulse: chroma-blue job complete.
done_chromar8x8  in  1  single-cycle pulse: chroma-red job complete.
start_luma4x4  out  1  single-cycle pulse: launch luma job at mb_x/mb_y/blk_idx.
start_chroma8x8  out  1  single-cycle pulse: launch both chroma jobs at mb_x/mb_y.
mb_x  out  $clog2(MB_COLS)  current macroblock column.
mb_y  out  $clog2(MB_ROWS)  current macroblock row.
blk_idx  out  4  luma 4x4 index within the MB, raster order: x=blk_idx[1:0], y=blk_idx[3:2].
busy  out  1  high from accepted frame_start until frame_done.
frame_done  out  1  single-cycle pulse: last macroblock complete.

Behaviour:
- Reset (asynchronous assert, low): state IDLE; every output 0; chroma done latches cleared. Reset during a frame aborts it immediately, with no frame_done pulse.
- States:
  - IDLE: wait for frame_start.
  - L_ISSUE: issue one luma job.
  - L_WAIT: wait for the luma job to finish.
  - C_ISSUE: issue the chroma jobs.
  - C_WAIT: wait for both chroma jobs to finish.
  - ADVANCE: move to the next macroblock or finish.
- IDLE:
  - frame_start=1 -> L_ISSUE next cycle, with mb_x=0, mb_y=0, blk_idx=0 and busy=1.
  - frame_start while busy is ignored.
- L_ISSUE:
  - If enable=1: start_luma4x4=1 for exactly this cycle, then -> L_WAIT.
  - If enable=0: hold in L_ISSUE with no pulse.
- L_WAIT:
  - On done_luma4x4 with blk_idx<15: blk_idx+1 and -> L_ISSUE, so the next start appears the cycle after done when enable=1.
  - On done_luma4x4 with blk_idx==15: blk_idx=0 and -> C_ISSUE.
- C_ISSUE:
  - If enable=1: start_chroma8x8=1 for one cycle, clear the chroma latches, -> C_WAIT.
  - If enable=0: hold with no pulse.
- C_WAIT:
  - Each chroma done sets its own sticky latch. The two may arrive in either order or in the same cycle.
  - When both latches are set (including a same-cycle update) -> ADVANCE.
- ADVANCE (one cycle):
  - If mb_x<MB_COLS-1: mb_x+1, -> L_ISSUE.
  - Else if mb_y<MB_ROWS-1: mb_x=0, mb_y+1, -> L_ISSUE.
  - Else: frame_done=1 this cycle, busy=0, mb_x=mb_y=0, -> IDLE.
- enable=0 never blocks waiting: dones are accepted in L_WAIT and C_WAIT regardless of enable; only issue states stall.
- Spurious dones (any done in a state not waiting for it) are ignored and never set latches.
- A luma done arriving during chroma states is ignored.
- mb_x, mb_y and blk_idx are stable from the cycle of a start pulse until the matching done.
- start_luma4x4 and start_chroma8x8 are never high in the same cycle.
- Per-MB minimum cycles with enable=1 and zero-latency engines: 16x2 (luma) + 2 (chroma) + 1 (advance) = 35.

Test Plan:
- WIDTH=32, LENGTH=32, enable=1, a behavioural engine model answering done 3 cycles after each start -> 64 start_luma4x4 and 4 start_chroma8x8 pulses. (mb_x,mb_y) visits (0,0),(1,0),(0,1),(1,1). blk_idx runs 0..15 per MB. One frame_done pulse, busy falls with it.
- Chroma dones: red 2 cycles before blue in MB0, both in the same cycle in MB1 -> ADVANCE entered exactly once per MB in each case, and the next start_luma4x4 appears 2 cycles after the last chroma done.
- Drop enable for 10 cycles while in L_WAIT, with done arriving at cycle 4 -> done accepted; start_luma4x4 for blk_idx+1 appears the cycle after enable rises, and not before.
- Spurious stimulus: done_luma4x4 in IDLE, done_chromab8x8 during L_WAIT, and frame_start mid-frame -> no state, counter or output change.
- Assert reset low at MB (1,0), blk_idx=7 -> all outputs 0 asynchronously, no frame_done. A new frame_start then restarts from (0,0), blk_idx=0.
- Default parameters, 1-cycle engine model -> exactly 3600 start_chroma8x8 pulses. Final MB reported as mb_x=79, mb_y=44. frame_done issued exactly once.

Source files
------------

// File: rtl/intra_mb_scheduler.sv
// Raster-order macroblock sequencer: sixteen luma 4x4 jobs, then one paired chroma 8x8 job per 16x16 MB.
// Start pulses decode directly from state; a done pulse is honoured only in the state waiting for it.
module intra_mb_scheduler #(
  parameter  int WIDTH   = 1280,
  parameter  int LENGTH  = 720,
  localparam int MB_COLS = WIDTH / 16,
  localparam int MB_ROWS = LENGTH / 16,
  localparam int XW      = (MB_COLS > 1) ? $clog2(MB_COLS) : 1,
  localparam int YW      = (MB_ROWS > 1) ? $clog2(MB_ROWS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          enable,
  input  logic          frame_start,
  input  logic          done_luma4x4,
  input  logic          done_chromab8x8,
  input  logic          done_chromar8x8,
  output logic          start_luma4x4,
  output logic          start_chroma8x8,
  output logic [XW-1:0] mb_x,
  output logic [YW-1:0] mb_y,
  output logic [3:0]    blk_idx,
  output logic          busy,
  output logic          frame_done
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    L_ISSUE = 3'd1,
    L_WAIT  = 3'd2,
    C_ISSUE = 3'd3,
    C_WAIT  = 3'd4,
    ADVANCE = 3'd5
  } state_t;

  localparam logic [XW-1:0] X_LAST = XW'(MB_COLS - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(MB_ROWS - 1);

  state_t        state_q, state_d;
  logic [XW-1:0] mb_x_q, mb_x_d;
  logic [YW-1:0] mb_y_q, mb_y_d;
  logic [3:0]    blk_q, blk_d;
  logic          cb_seen_q, cb_seen_d;
  logic          cr_seen_q, cr_seen_d;
  logic          start_l, start_c, fdone;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      mb_x_q    <= '0;
      mb_y_q    <= '0;
      blk_q     <= '0;
      cb_seen_q <= 1'b0;
      cr_seen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mb_x_q    <= mb_x_d;
      mb_y_q    <= mb_y_d;
      blk_q     <= blk_d;
      cb_seen_q <= cb_seen_d;
      cr_seen_q <= cr_seen_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mb_x_d    = mb_x_q;
    mb_y_d    = mb_y_q;
    blk_d     = blk_q;
    cb_seen_d = cb_seen_q;
    cr_seen_d = cr_seen_q;
    start_l   = 1'b0;
    start_c   = 1'b0;
    fdone     = 1'b0;
    case (state_q)
      IDLE: begin
        if (frame_start) begin
          state_d = L_ISSUE;
          mb_x_d  = '0;
          mb_y_d  = '0;
          blk_d   = '0;
        end
      end
      L_ISSUE: begin
        if (enable) begin
          start_l = 1'b1;
          state_d = L_WAIT;
        end
      end
      L_WAIT: begin
        if (done_luma4x4) begin
          if (blk_q == 4'd15) begin
            blk_d   = '0;
            state_d = C_ISSUE;
          end else begin
            blk_d   = blk_q + 4'd1;
            state_d = L_ISSUE;
          end
        end
      end
      C_ISSUE: begin
        if (enable) begin
          start_c   = 1'b1;
          cb_seen_d = 1'b0;
          cr_seen_d = 1'b0;
          state_d   = C_WAIT;
        end
      end
      C_WAIT: begin
        // Sticky latches let blue and red finish in either order or together.
        cb_seen_d = cb_seen_q | done_chromab8x8;
        cr_seen_d = cr_seen_q | done_chromar8x8;
        if (cb_seen_d && cr_seen_d) begin
          state_d = ADVANCE;
        end
      end
      ADVANCE: begin
        if (mb_x_q != X_LAST) begin
          mb_x_d  = mb_x_q + 1'b1;
          state_d = L_ISSUE;
        end else if (mb_y_q != Y_LAST) begin
          mb_x_d  = '0;
          mb_y_d  = mb_y_q + 1'b1;
          state_d = L_ISSUE;
        end else begin
          fdone   = 1'b1;
          mb_x_d  = '0;
          mb_y_d  = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign start_luma4x4   = start_l;
  assign start_chroma8x8 = start_c;
  assign frame_done      = fdone;
  assign busy            = (state_q != IDLE);
  assign mb_x            = mb_x_q;
  assign mb_y            = mb_y_q;
  assign blk_idx         = blk_q;

endmodule

// File: tb/tb_intra_mb_scheduler.sv
// Bench for a 2x2-macroblock frame: job-order scoreboard, latency table, and stall/spurious/reset sequences.
module tb_intra_mb_scheduler;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       frame_start;
  logic       done_luma4x4, done_chromab8x8, done_chromar8x8;
  logic       start_luma4x4, start_chroma8x8;
  logic [0:0] mb_x;
  logic [0:0] mb_y;
  logic [3:0] blk_idx;
  logic       busy;
  logic       frame_done;

  intra_mb_scheduler #(.WIDTH(32), .LENGTH(32)) dut (
    .clk             (clk),
    .reset           (reset),
    .enable          (enable),
    .frame_start     (frame_start),
    .done_luma4x4    (done_luma4x4),
    .done_chromab8x8 (done_chromab8x8),
    .done_chromar8x8 (done_chromar8x8),
    .start_luma4x4   (start_luma4x4),
    .start_chroma8x8 (start_chroma8x8),
    .mb_x            (mb_x),
    .mb_y            (mb_y),
    .blk_idx         (blk_idx),
    .busy            (busy),
    .frame_done      (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Engine model: done arrives N cycles after the cycle of the start pulse.
  logic eng_l = 1'b0, eng_b = 1'b0, eng_r = 1'b0;
  logic man_l, man_b, man_r;
  bit   eng_on;
  int   ll = 1, cbl = 1, crl = 1;
  int   lc = 0, bc = 0, rc = 0;
  bit   seen_l = 1'b0, seen_c = 1'b0;

  assign done_luma4x4    = eng_l | man_l;
  assign done_chromab8x8 = eng_b | man_b;
  assign done_chromar8x8 = eng_r | man_r;

  always @(posedge clk) begin
    #1;
    eng_l = 1'b0;
    eng_b = 1'b0;
    eng_r = 1'b0;
    if (!reset) begin
      lc = 0; bc = 0; rc = 0;
    end else begin
      if (eng_on && seen_l) lc = ll;
      if (eng_on && seen_c) begin bc = cbl; rc = crl; end
      if (lc > 0) begin lc--; if (lc == 0) eng_l = 1'b1; end
      if (bc > 0) begin bc--; if (bc == 0) eng_b = 1'b1; end
      if (rc > 0) begin rc--; if (rc == 0) eng_r = 1'b1; end
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Scoreboard of expected jobs in issue order.
  typedef struct {
    bit c;
    int x;
    int y;
    int b;
  } job_t;
  job_t sbq[$];
  job_t e;

  task automatic push_frame();
    for (int y = 0; y < 2; y++)
      for (int x = 0; x < 2; x++) begin
        for (int b = 0; b < 16; b++) sbq.push_back('{c: 1'b0, x: x, y: y, b: b});
        sbq.push_back('{c: 1'b1, x: x, y: y, b: 0});
      end
  endtask

  int  n_l, n_c, n_fd, first_cyc, fd_cyc, fs_cyc, last_cd;
  bit  pend_gap;
  int  act_key, exp_key;

  always @(negedge clk) begin
    seen_l = start_luma4x4;
    seen_c = start_chroma8x8;
    if (pend_gap && (done_chromab8x8 || done_chromar8x8)) last_cd = cyc;
    if (start_luma4x4) begin
      n_l++;
      if (first_cyc < 0) first_cyc = cyc;
      if (pend_gap) begin
        chk("chroma_done_to_luma_start", cyc - last_cd, 2);
        pend_gap = 1'b0;
      end
    end
    if (start_chroma8x8) begin
      n_c++;
      pend_gap = 1'b1;
    end
    if (frame_done) begin
      n_fd++;
      fd_cyc   = cyc;
      pend_gap = 1'b0;
    end
    if (start_luma4x4 || start_chroma8x8) begin
      act_key = (int'(start_chroma8x8) << 21) | (int'(start_luma4x4) << 20) |
                (int'(mb_x) << 12) | (int'(mb_y) << 4) | int'(blk_idx);
      if (sbq.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_start: got job key 0x%0h, expected no start", act_key);
      end else begin
        e = sbq.pop_front();
        exp_key = (int'(e.c) << 21) | (int'(!e.c) << 20) | (e.x << 12) | (e.y << 4) | e.b;
        chk("job_key", act_key, exp_key);
      end
    end
  end

  task automatic wait_fd(input int lim);
    for (int i = 0; i < lim && n_fd == 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (n_fd == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL frame_done_timeout: got none within %0d cycles, expected one", lim);
    end
  endtask

  task automatic run_frame();
    n_l = 0; n_c = 0; n_fd = 0; first_cyc = -1; fd_cyc = -1; pend_gap = 1'b0;
    push_frame();
    @(posedge clk); #1 frame_start = 1'b1; fs_cyc = cyc;
    @(posedge clk); #1 frame_start = 1'b0;
    wait_fd(3000);
    @(posedge clk);
    @(negedge clk);
    chk("busy_after_frame_done", int'(busy), 0);
    chk("frame_done_single_cycle", int'(frame_done), 0);
  endtask

  typedef struct {
    int ll;
    int cb;
    int cr;
    int exp_cyc;
    int exp_l;
    int exp_c;
  } vec_t;
  vec_t vt[5];

  int  stall_starts;
  bit  found;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1);
  end

  initial begin
    // Cycles from first luma start to frame_done = 4*(16*(ll+1) + max(cb,cr) + 2) - 1.
    vt[0] = '{ll: 3, cb: 3, cr: 3, exp_cyc: 275, exp_l: 64, exp_c: 4};
    vt[1] = '{ll: 1, cb: 1, cr: 1, exp_cyc: 139, exp_l: 64, exp_c: 4};
    vt[2] = '{ll: 1, cb: 5, cr: 3, exp_cyc: 155, exp_l: 64, exp_c: 4};
    vt[3] = '{ll: 1, cb: 2, cr: 2, exp_cyc: 143, exp_l: 64, exp_c: 4};
    vt[4] = '{ll: 2, cb: 1, cr: 4, exp_cyc: 215, exp_l: 64, exp_c: 4};

    reset = 1'b1; enable = 1'b0; frame_start = 1'b0;
    man_l = 1'b0; man_b = 1'b0; man_r = 1'b0; eng_on = 1'b0;
    #1 reset = 1'b0;
    #2;
    chk("rst_start_luma", int'(start_luma4x4), 0);
    chk("rst_start_chroma", int'(start_chroma8x8), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_mb_x", int'(mb_x), 0);
    chk("rst_mb_y", int'(mb_y), 0);
    chk("rst_blk_idx", int'(blk_idx), 0);
    @(posedge clk); #1 reset = 1'b1;

    for (int r = 0; r < 5; r++) begin
      ll = vt[r].ll; cbl = vt[r].cb; crl = vt[r].cr;
      eng_on = 1'b1; enable = 1'b1;
      run_frame();
      chk("first_start_latency", first_cyc - fs_cyc, 1);
      chk("frame_cycles", fd_cyc - first_cyc, vt[r].exp_cyc);
      chk("luma_starts", n_l, vt[r].exp_l);
      chk("chroma_starts", n_c, vt[r].exp_c);
      chk("frame_done_count", n_fd, 1);
      chk("scoreboard_drained", sbq.size(), 0);
    end

    // Enable stall in L_WAIT with the done landing mid-stall.
    eng_on = 1'b0; ll = 1; cbl = 1; crl = 1; enable = 1'b1;
    n_fd = 0; pend_gap = 1'b0;
    push_frame();
    @(posedge clk); #1 frame_start = 1'b1;
    @(posedge clk); #1 frame_start = 1'b0;
    @(negedge clk);
    chk("stall_first_start", int'(start_luma4x4), 1);
    @(posedge clk); #1 enable = 1'b0;
    stall_starts = 0;
    for (int i = 0; i < 10; i++) begin
      man_l = (i == 3);
      @(negedge clk);
      stall_starts += int'(start_luma4x4);
      if (i == 9) chk("stall_blk_after_done", int'(blk_idx), 1);
      @(posedge clk); #1;
    end
    chk("stall_no_start", stall_starts, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("start_after_enable", int'(start_luma4x4), 1);
    chk("blk_after_enable", int'(blk_idx), 1);

    // Spurious chroma done and frame_start while waiting on luma.
    @(posedge clk); #1 man_b = 1'b1; frame_start = 1'b1;
    @(posedge clk); #1 man_b = 1'b0; frame_start = 1'b0;
    @(negedge clk);
    chk("spur_busy", int'(busy), 1);
    chk("spur_blk_idx", int'(blk_idx), 1);
    chk("spur_mb_x", int'(mb_x), 0);
    chk("spur_mb_y", int'(mb_y), 0);
    chk("spur_start_luma", int'(start_luma4x4), 0);
    chk("spur_start_chroma", int'(start_chroma8x8), 0);
    @(posedge clk); #1 man_l = 1'b1;
    @(posedge clk); #1 man_l = 1'b0; eng_on = 1'b1;

    // Abort with reset at MB (1,0), block 7.
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (start_luma4x4 && mb_x == 1'b1 && mb_y == 1'b0 && blk_idx == 4'd7) found = 1'b1;
    end
    chk("reach_mb1_blk7", int'(found), 1);
    #2 reset = 1'b0;
    #1;
    chk("abort_start_luma", int'(start_luma4x4), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_mb_x", int'(mb_x), 0);
    chk("abort_blk_idx", int'(blk_idx), 0);
    chk("abort_frame_done", int'(frame_done), 0);
    eng_on = 1'b0;
    sbq.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Luma done while idle must not start anything.
    man_l = 1'b1;
    @(posedge clk); #1 man_l = 1'b0;
    @(negedge clk);
    chk("idle_done_busy", int'(busy), 0);
    chk("idle_done_start", int'(start_luma4x4), 0);
    chk("idle_done_blk", int'(blk_idx), 0);
    chk("abort_no_frame_done", n_fd, 0);

    // Fresh frame after the abort restarts at (0,0) block 0.
    eng_on = 1'b1; ll = 1; cbl = 1; crl = 1;
    run_frame();
    chk("restart_luma_starts", n_l, 64);
    chk("restart_chroma_starts", n_c, 4);
    chk("restart_frame_done_count", n_fd, 1);
    chk("restart_scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
